// File: rtl/jk_cmd_pkg.sv
// Shared types and defaults for the J/K command front-end.
// JK_CMD_TOGGLE_EN selects whether a paired press emits a toggle (J=K=1) or nothing.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAIR,
    ST_EMIT,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMD_SET,
    CMD_CLR,
    CMD_TGL
  } cmd_t;

  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_PAIR_WIN   = 4;

  // Returns {J, K}; without toggle support a pair is a conflict and drives nothing.
  function automatic logic [1:0] cmd_to_jk(input cmd_t cmd);
    logic [1:0] jk;
    jk = 2'b00;
    case (cmd)
      CMD_SET: jk = 2'b10;
      CMD_CLR: jk = 2'b01;
`ifdef JK_CMD_TOGGLE_EN
      CMD_TGL: jk = 2'b11;
`else
      CMD_TGL: jk = 2'b00;
`endif
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter and a one-cycle press pulse
// on the debounced 0->1 edge.
module jk_btn_debounce
  import jk_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn,
  output logic oLevel,
  output logic oPress
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= iBtn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample agreeing with the current level restarts the stability run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign oLevel = r_level;
  assign oPress = r_level & ~r_level_d;

endmodule

// File: rtl/jk_cmd_debounce.sv
// Debounced set/clear buttons paired into one single-cycle J/K command per gesture.
// JK_CMD_TOGGLE_EN: paired presses emit J=K=1; otherwise a pair emits nothing.
module jk_cmd_debounce
  import jk_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PAIR_WIN   = DEF_PAIR_WIN
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtnSet,
  input  logic iBtnClr,
  output logic oJ,
  output logic oK,
  output logic oBusy
);

  localparam int WW = $clog2(PAIR_WIN + 1);

  logic w_lvl_set;
  logic w_lvl_clr;
  logic w_press_set;
  logic w_press_clr;
  logic w_other_press;

  state_t        r_state;
  cmd_t          r_cmd;
  logic [WW-1:0] r_win;
  logic          r_j;
  logic          r_k;

  jk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .iClk   (iClk),
    .iRst   (iRst),
    .iBtn   (iBtnSet),
    .oLevel (w_lvl_set),
    .oPress (w_press_set)
  );

  jk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .iClk   (iClk),
    .iRst   (iRst),
    .iBtn   (iBtnClr),
    .oLevel (w_lvl_clr),
    .oPress (w_press_clr)
  );

  // Only the button that did not open the window can complete a pair.
  assign w_other_press = (r_cmd == CMD_SET) ? w_press_clr : w_press_set;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_SET;
      r_win   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      r_j <= 1'b0;
      r_k <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_press_set && w_press_clr) begin
            r_state    <= ST_EMIT;
            r_cmd      <= CMD_TGL;
            {r_j, r_k} <= cmd_to_jk(CMD_TGL);
          end else if (w_press_set || w_press_clr) begin
            r_state <= ST_PAIR;
            r_cmd   <= w_press_set ? CMD_SET : CMD_CLR;
            r_win   <= '0;
          end
        end
        ST_PAIR: begin
          if (w_other_press && (r_win < WW'(PAIR_WIN))) begin
            r_state    <= ST_EMIT;
            r_cmd      <= CMD_TGL;
            {r_j, r_k} <= cmd_to_jk(CMD_TGL);
          end else if (r_win == WW'(PAIR_WIN)) begin
            r_state    <= ST_EMIT;
            {r_j, r_k} <= cmd_to_jk(r_cmd);
          end else begin
            r_win <= r_win + WW'(1);
          end
        end
        ST_EMIT: r_state <= ST_HOLD;
        ST_HOLD: begin
          if (!w_lvl_set && !w_lvl_clr) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oJ    = r_j;
  assign oK    = r_k;
  assign oBusy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Scoreboard bench: a timestamp-based gesture model pushes expected emits, a negedge
// monitor compares J/K and busy every cycle.
module tb_jk_cmd_debounce;

  localparam int DEB  = 16;
  localparam int PW   = 4;
  localparam int MAXC = 16384;

  logic clk;
  logic iRst;
  logic iBtnSet;
  logic iBtnClr;
  logic oJ;
  logic oK;
  logic oBusy;

  jk_cmd_debounce #(.DEB_CYCLES(DEB), .PAIR_WIN(PW)) dut (
    .iClk    (clk),
    .iRst    (iRst),
    .iBtnSet (iBtnSet),
    .iBtnClr (iBtnClr),
    .oJ      (oJ),
    .oK      (oK),
    .oBusy   (oBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         e;
    logic [1:0] jk;
    int         cmd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state (written only by the model process).
  int  edge_n = 0;
  int  rlast  = -100;
  bit  rawh [2][MAXC];
  bit  lvl  [2];
  bit  lvlp [2];
  bit  pending = 0;
  bit  holding = 0;
  bit  m_busy  = 0;
  int  t1 = 0;
  int  first = 0;
  int  hold_start = 0;

  // Expected {J,K} for command 0=set, 1=clear, 2=pair.
  function automatic logic [1:0] exp_jk(input int cmd);
    if (cmd == 0) return 2'b10;
    if (cmd == 1) return 2'b01;
`ifdef JK_CMD_TOGGLE_EN
    return 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  // Synchronised sample seen by the debouncer at edge k: raw input two edges earlier,
  // forced low while the synchroniser is still refilling after reset.
  function automatic bit seen(input int b, input int k);
    if (k - 2 > rlast && k - 2 >= 0) return rawh[b][k-2];
    return 1'b0;
  endfunction

  // Level flips at edge n when the last DEB post-reset samples all disagree with it.
  function automatic bit flips(input int b, input int n);
    for (int k = n - DEB + 1; k <= n; k++) begin
      if (k <= rlast || seen(b, k) == lvl[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic emit(input int cmd);
    exp_t x;
    x.e   = edge_n;
    x.jk  = exp_jk(cmd);
    x.cmd = cmd;
    exp_q.push_back(x);
    pending    = 0;
    holding    = 1;
    hold_start = edge_n + 2;
  endtask

  initial begin
    bit ev [2];
    bit nl [2];
    forever begin
      @(posedge clk);
      edge_n++;
      if (edge_n < MAXC) begin
        rawh[0][edge_n] = iBtnSet;
        rawh[1][edge_n] = iBtnClr;
      end
      if (iRst) begin
        rlast   = edge_n;
        lvl[0]  = 0; lvl[1]  = 0;
        lvlp[0] = 0; lvlp[1] = 0;
        pending = 0;
        holding = 0;
      end else begin
        for (int b = 0; b < 2; b++) ev[b] = lvl[b] && !lvlp[b];
        if (holding) begin
          if (edge_n >= hold_start && !lvl[0] && !lvl[1]) holding = 0;
        end else if (pending) begin
          if (ev[1-first] && edge_n <= t1 + PW) emit(2);
          else if (edge_n == t1 + PW + 1) emit(first);
        end else begin
          if (ev[0] && ev[1]) emit(2);
          else if (ev[0] || ev[1]) begin
            pending = 1;
            t1      = edge_n;
            first   = ev[0] ? 0 : 1;
          end
        end
        for (int b = 0; b < 2; b++) nl[b] = flips(b, edge_n) ? !lvl[b] : lvl[b];
        for (int b = 0; b < 2; b++) begin
          lvlp[b] = lvl[b];
          lvl[b]  = nl[b];
        end
      end
      m_busy = pending || holding;
    end
  end

  // Monitor: one J/K check and one busy check per cycle.
  initial begin
    logic [1:0] want;
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        want = 2'b00;
        if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
          want = exp_q[0].jk;
          $display("emit @edge %0d cmd=%0d J=%b K=%b want %b", edge_n, exp_q[0].cmd, oJ, oK, want);
          void'(exp_q.pop_front());
        end
        checks++;
        if ({oJ, oK} !== want) begin
          errors++;
          $display("FAIL jk @edge %0d: got %b want %b", edge_n, {oJ, oK}, want);
        end
        checks++;
        if (oBusy !== m_busy) begin
          errors++;
          $display("FAIL busy @edge %0d: got %b want %b", edge_n, oBusy, m_busy);
        end
      end
    end
  end

  function automatic logic wave(input int t, input int start, input int bl,
                                input int per, input int stop);
    if (start < 0 || t < start || t >= stop) return 1'b0;
    if (t < start + bl) return ((t - start) / per) % 2 == 0;
    return 1'b1;
  endfunction

  task automatic run_scn(input int id, input int s_st, input int s_bl, input int s_per,
                         input int s_sp, input int c_st, input int c_bl, input int c_per,
                         input int c_sp, input int rst_t, input int len);
    $display("scn %0d set=%0d..%0d clr=%0d..%0d rst=%0d", id, s_st, s_sp, c_st, c_sp, rst_t);
    for (int t = 0; t < len; t++) begin
      iBtnSet = wave(t, s_st, s_bl, s_per, s_sp);
      iBtnClr = wave(t, c_st, c_bl, c_per, c_sp);
      iRst    = (rst_t >= 0 && t >= rst_t && t < rst_t + 3);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int s_st, s_bl, s_per, s_sp, c_st, c_bl, c_per, c_sp, rst_t, len;
    iRst = 1'b1; iBtnSet = 1'b0; iBtnClr = 1'b0;
    // Reset with both buttons held, then a fresh debounce.
    run_scn(0, 0, 0, 1, 60, 0, 0, 1, 60, 0, 110);
    // Clean set press.
    run_scn(1, 5, 0, 1, 50, -1, 0, 1, 0, -1, 95);
    // Bouncing clear then steady.
    run_scn(2, -1, 0, 1, 0, 5, 30, 3, 90, -1, 140);
    // Clear 2 cycles after set: inside the window.
    run_scn(3, 5, 0, 1, 50, 7, 0, 1, 50, -1, 95);
    // Clear 6 cycles after set: outside the window.
    run_scn(4, 5, 0, 1, 50, 11, 0, 1, 60, -1, 105);
    // Reset while pairing, set still held.
    run_scn(5, 5, 0, 1, 80, -1, 0, 1, 0, 25, 130);
    for (int i = 6; i < 46; i++) begin
      s_st  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 12));
      c_st  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 18));
      s_bl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : 0;
      c_bl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : 0;
      s_per = $urandom_range(1, 5);
      c_per = $urandom_range(1, 5);
      s_sp  = (s_st < 0 ? 0 : s_st) + s_bl + int'($urandom_range(10, 40));
      c_sp  = (c_st < 0 ? 0 : c_st) + c_bl + int'($urandom_range(10, 40));
      rst_t = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 60)) : -1;
      len   = ((s_sp > c_sp) ? s_sp : c_sp) + 45;
      if (rst_t + 3 > len) len = rst_t + 45;
      run_scn(i, s_st, s_bl, s_per, s_sp, c_st, c_bl, c_per, c_sp, rst_t, len);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_emits: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_cmd_debounce.md
# jk_cmd_debounce

Command front-end that sits directly upstream of the JK flip-flop stage and drives its J/K inputs. It synchronises and debounces two raw push-buttons (set and clear). It then pairs near-simultaneous presses and issues exactly one single-cycle J/K command per accepted gesture: set (J), clear (K), or toggle (J and K together). The downstream flip-flop shares the same clock.

## Interface
Parameters:
- DEB_CYCLES, 16: consecutive identical synchronised samples required to change a debounced level (≥2).
- PAIR_WIN, 4: cycles after the first press event during which a second press counts as simultaneous (≥1).

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  reset, synchronous, active-high.
- iBtnSet  input  1  raw set button, asynchronous, active-high, may bounce.
- iBtnClr  input  1  raw clear button, asynchronous, active-high, may bounce.
- oJ  output  1  J command to flip-flop; one-cycle pulse.
- oK  output  1  K command to flip-flop; one-cycle pulse.
- oBusy  output  1  high whenever the main FSM is not IDLE.

## Operation
- Per button: 2-flop synchroniser, then debounce counter. The counter resets whenever the synchronised sample equals the debounced level. When it reaches DEB_CYCLES−1 while the sample still differs, the debounced level flips and the counter clears.
- Press event: one-cycle internal pulse on the debounced level 0→1. Release generates no event.
- Main FSM states:
  - IDLE: on a press event, go to PAIR and load window counter = 0. If both buttons' events occur in the same cycle, go straight to EMIT with a toggle.
  - PAIR: the window counter increments each cycle.
    - If the other button's event arrives while counter < PAIR_WIN, go to EMIT with a toggle.
    - When the counter reaches PAIR_WIN, go to EMIT with the first button's command.
    - A repeat event from the same button is ignored.
  - EMIT: one cycle. oJ/oK are driven per the command (set: J=1,K=0; clear: J=0,K=1; toggle: J=1,K=1). Next state is HOLD.
  - HOLD: leave for IDLE when both debounced levels are 0. All press events in HOLD are discarded.
- oJ/oK are registered outputs, high only in the EMIT cycle. J=K=0 at all other times.
- Reset:
  - oJ=0, oK=0, oBusy=0, FSM=IDLE.
  - Synchroniser flops, debounced levels and all counters are cleared to 0.
  - Reset asserted mid-gesture aborts it and emits nothing. A button still held after reset must debounce afresh, then produces a new press.

## Timing
- Raw input first sampled high at edge e0 and clean thereafter: debounced level rises at edge e0+DEB_CYCLES+1. The press event is visible in the following cycle.
- Single press, defaults: oJ (or oK) high for exactly the one cycle following edge e0+DEB_CYCLES+PAIR_WIN+3, i.e. 23 cycles after e0.
- Pair: EMIT follows the second press event by one cycle, regardless of remaining window.
- Bounce shorter than DEB_CYCLES cycles never changes a debounced level.
- Minimum spacing of two commands: one EMIT per gesture. A new gesture needs both buttons released (debounced) first.

## Configuration
- JK_CMD_TOGGLE_EN defined: paired presses emit toggle (oJ=oK=1 for one cycle).
- Undefined: a pair is treated as a conflict. EMIT drives oJ=oK=0, but the FSM still passes through EMIT and HOLD, with oBusy high, as above.

## Structure
- Shared package/header jk_cmd_pkg: FSM state encoding (IDLE, PAIR, EMIT, HOLD), command encoding (CMD_SET, CMD_CLR, CMD_TGL), default DEB_CYCLES/PAIR_WIN constants.
- One sub-module jk_btn_debounce (synchroniser + debounce counter + press-event pulse), instantiated twice. Top holds the pairing FSM and output registers.

## Test plan
- Reset: hold iRst 3 cycles with both buttons high → oJ=oK=oBusy=0. After release, the buttons debounce anew → one EMIT after 23 cycles.
- Clean set press at e0, defaults → oJ=1,oK=0 for exactly one cycle 23 cycles after e0; oBusy high from press event until release is debounced.
- Bouncing clear (toggles every 3 cycles for 30 cycles, then steady high) → exactly one oK pulse; no spurious oJ.
- Set, then clear 2 cycles later (within PAIR_WIN=4), with JK_CMD_TOGGLE_EN → single cycle oJ=oK=1. Without the macro → no pulse, oBusy still cycles IDLE→…→IDLE.
- Set, then clear 6 cycles later (outside window) → oJ pulse only; the clear press in HOLD is ignored until both are released.
- iRst asserted while in PAIR → no pulse, all outputs 0 next cycle, FSM IDLE.
